instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Front-end stage directly upstream of the control decoder.
- Holds the PC and issues one request at a time to instruction memory.
- Captures the returned word and presents it to decode as instruction_code with a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
PC_STEP, 4, byte increment applied to PC after each accepted fetch

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  single-cycle fetch request strobe
imem_addr  output  32  byte address of fetch, valid when imem_req=1
imem_rvalid  input  1  response strobe from instruction memory, latency ≥1 cycle
imem_rdata  input  32  instruction word, valid when imem_rvalid=1
instr_valid  output  1  instruction_code/pc_out hold a valid instruction
instr_ready  input  1  decode accepts instruction this cycle
instruction_code  output  32  fetched instruction to control/decode
pc_out  output  32  address of instruction_code
redirect_valid  input  1  branch taken / jump; replace PC
redirect_pc  input  32  new PC; bits [1:0] forced to 0 internally

Behaviour:
- Reset (async assert, sync release):
  - state=S_ISSUE, pc=RESET_PC, imem_req=0 (registered), instr_valid=0.
  - instruction_code=32'h0000_0013 (NOP), pc_out=0.
- States:
  - S_ISSUE: imem_req=1, imem_addr=pc for exactly one cycle; next S_WAIT.
  - S_WAIT: wait for imem_rvalid. On rvalid: instruction_code<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+PC_STEP; next S_HOLD.
  - S_HOLD: instr_valid=1, outputs stable. If instr_ready, instr_valid<=0; next S_ISSUE.
  - S_DROP: a stale response is outstanding. On imem_rvalid the response is discarded; next S_ISSUE. imem_req=0.
- Redirect (redirect_valid=1) has priority over all other events in the same cycle:
  - pc<={redirect_pc[31:2],2'b00}; instr_valid<=0, regardless of instr_ready.
  - From S_ISSUE: the request for the old pc is already out; next S_DROP.
  - From S_WAIT with imem_rvalid=0: next S_DROP.
  - From S_WAIT with imem_rvalid=1: the response is discarded; next S_ISSUE.
  - From S_HOLD: the held instruction is squashed; next S_ISSUE.
  - From S_DROP: stay in S_DROP with the new pc. If imem_rvalid=1 in the same cycle, the response is discarded and next is S_ISSUE.
- At most one outstanding memory request, ever.
- Best-case throughput: one instruction per 3 cycles at 1-cycle memory latency.
- pc arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- imem_rvalid in S_ISSUE or S_HOLD is a protocol error; it is ignored.
- Reset asserted mid-fetch: all state clears immediately. A response arriving after release while in S_ISSUE is ignored per the rule above.
- instruction_code and pc_out change only on capture; they hold their value when instr_valid drops.

Optional Feature:
- Macro: INSTR_FETCH_STATS_EN.
- Defined:
  - Adds output fetch_cnt[31:0]: increments on each instr_valid&instr_ready handshake without a same-cycle redirect.
  - Adds output squash_cnt[15:0]: increments on each redirect that discards a held, in-flight, or same-cycle response.
  - Both counters reset to 0 and wrap silently.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, memory latency 1, instr_ready=1, memory returns addr-tagged words -> imem_req pulses at addr 0,4,8; instruction_code sequence matches; instr_valid high one cycle each, every third cycle.
- instr_ready=0 for 5 cycles after first capture -> instr_valid and instruction_code stable; no new imem_req until ready rises; pc_out=0.
- Redirect to 32'h100 in the S_ISSUE cycle for addr 8 -> rdata for addr 8 dropped when it returns; next imem_req at 32'h100; no instr_valid for 8.
- Redirect coincident with imem_rvalid in S_WAIT, redirect_pc=32'h203 -> response discarded; next imem_addr=32'h200.
- pc=32'hFFFF_FFFC fetch accepted -> next imem_addr=0.
- rst_n pulled low while in S_WAIT -> outputs return to reset values asynchronously; first request after release is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: holds the PC, issues one imem request at a time and hands words to decode.
// Optional fetch/squash statistics counters are enabled by defining INSTR_FETCH_STATS_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction_code,
    output logic [31:0] pc_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef INSTR_FETCH_STATS_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [15:0] squash_cnt
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        req_q;
    logic        capture;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_req  = req_q;
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        case (state)
            // req_q low in S_ISSUE only right after reset: spend one cycle raising the strobe
            S_ISSUE: if (req_q) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    capture   = 1'b1;
                    pc_nxt    = pc + PC_STEP;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD:  if (instr_ready) state_nxt = S_ISSUE;
            S_DROP:  if (imem_rvalid) state_nxt = S_ISSUE;
            default: state_nxt = S_ISSUE;
        endcase

        if (redirect_valid) begin
            capture = 1'b0;
            pc_nxt  = {redirect_pc[31:2], 2'b00};
            case (state)
                S_ISSUE:        state_nxt = req_q ? S_DROP : S_ISSUE;
                S_WAIT, S_DROP: state_nxt = imem_rvalid ? S_ISSUE : S_DROP;
                default:        state_nxt = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_ISSUE;
            pc          <= RESET_PC;
            req_q       <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            req_q       <= (state_nxt == S_ISSUE);
            instr_valid <= (state_nxt == S_HOLD);
        end
    end

    // Delivered word and its address only move on capture; they persist after instr_valid drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction_code <= NOP_INSTR;
            pc_out           <= 32'h0000_0000;
        end else if (capture) begin
            instruction_code <= imem_rdata;
            pc_out           <= pc;
        end
    end

`ifdef INSTR_FETCH_STATS_EN
    logic fetch_evt;
    logic squash_evt;

    assign fetch_evt  = instr_valid & instr_ready & ~redirect_valid;
    assign squash_evt = redirect_valid &
                        ((state == S_HOLD) || (state == S_WAIT) ||
                         ((state == S_ISSUE) && req_q) ||
                         ((state == S_DROP) && imem_rvalid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= 32'd0;
            squash_cnt <= 16'd0;
        end else begin
            if (fetch_evt)  fetch_cnt  <= fetch_cnt + 32'd1;
            if (squash_evt) squash_cnt <= squash_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: program-order PC model, latency-randomised memory, random ready/redirects.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction_code;
    logic [31:0] pc_out;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef INSTR_FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [15:0] squash_cnt;
`endif

    instr_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction_code(instruction_code),
        .pc_out(pc_out),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
`ifdef INSTR_FETCH_STATS_EN
        ,
        .fetch_cnt(fetch_cnt),
        .squash_cnt(squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // memory returns an address-tagged word so mis-ordered deliveries are visible
    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Stimulus controls
    int          lat_mode   = 1;   // 0: random 1..4, else fixed latency
    int          ready_mode = 1;   // 0: low, 1: high, 2: random
    bit          redir_rand = 0;
    bit          chk_gap    = 0;
    bit          hook_req_en = 0;
    logic [31:0] hook_req_addr, hook_req_tgt;
    bit          hook_rv_en = 0;
    logic [31:0] hook_rv_tgt;
    bit          hook_now_en = 0;
    logic [31:0] hook_now_tgt;

    // Reference model state
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    bit          mem_busy = 0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    // Driver + memory + architectural model, acting just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_busy = 0;
                exp_q.delete();
                addr_q.delete();
                model_pc       = RESET_PC;
                imem_rvalid    = 1'b0;
                redirect_valid = 1'b0;
                instr_ready    = 1'b0;
                continue;
            end
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = tag(mem_addr);
                    mem_busy    = 0;
                end
            end
            if (imem_req) begin
                check("one_outstanding", {31'b0, mem_busy}, 32'd0);
                addr_q.push_back(model_pc);
                exp_q.push_back(model_pc);
                mem_busy = 1;
                mem_addr = imem_addr;
                mem_cnt  = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
            end
            case (ready_mode)
                0:       instr_ready = 1'b0;
                1:       instr_ready = 1'b1;
                default: instr_ready = $urandom_range(0, 1) == 1;
            endcase
            redirect_valid = 1'b0;
            if (hook_now_en) begin
                redirect_valid = 1'b1; redirect_pc = hook_now_tgt; hook_now_en = 0;
            end else if (hook_req_en && imem_req && imem_addr == hook_req_addr) begin
                redirect_valid = 1'b1; redirect_pc = hook_req_tgt; hook_req_en = 0;
            end else if (hook_rv_en && imem_rvalid && exp_q.size() > 0 && !instr_valid) begin
                redirect_valid = 1'b1; redirect_pc = hook_rv_tgt; hook_rv_en = 0;
            end else if (redir_rand && $urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : $urandom;
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc & ~32'h3;
            end else if (instr_valid && instr_ready) begin
                model_pc = model_pc + 32'd4;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or a delivery
    int          cyc = 0;
    int          last_hs = -1;
    int          idle = 0;
    bit          prev_valid = 0;
    bit          prev_done = 0;
    logic [31:0] prev_code, prev_pc;

    initial begin
        forever begin
            logic [31:0] e;
            bit          hs;
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_valid = 0; last_hs = -1; idle = 0;
                continue;
            end
            if (imem_req) begin
                if (addr_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
                else check("imem_addr", imem_addr, addr_q.pop_front());
                check("req_while_valid", {31'b0, instr_valid}, 32'd0);
            end
            if (prev_valid && !prev_done) begin
                check("hold_valid", {31'b0, instr_valid}, 32'd1);
                check("hold_code", instruction_code, prev_code);
                check("hold_pc", pc_out, prev_pc);
            end
            hs = instr_valid && instr_ready && !redirect_valid;
            if (hs) begin
                if (exp_q.size() == 0) check("deliver_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("pc_out", pc_out, e);
                    check("instr_code", instruction_code, tag(e));
                end
                if (chk_gap && last_hs >= 0) check("hs_gap", 32'(cyc - last_hs), 32'd3);
                last_hs = cyc;
                idle = 0;
            end else begin
                idle++;
            end
            if (redirect_valid) begin
                last_hs = -1;
                idle = 0;
            end
            if (idle > 200) begin
                check("progress_timeout", 32'd0, 32'd1);
                idle = 0;
            end
            prev_valid = instr_valid;
            prev_done  = hs || redirect_valid;
            prev_code  = instruction_code;
            prev_pc    = pc_out;
        end
    end

    task automatic check_reset_values(input string tag_s);
        check({tag_s, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag_s, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag_s, "_code"}, instruction_code, NOP);
        check({tag_s, "_pc_out"}, pc_out, 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        release_reset();

        // Stall: first instruction held with ready low
        lat_mode = 1; ready_mode = 0;
        for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_pc_out", pc_out, 32'd0);
            check("stall_code", instruction_code, tag(32'd0));
            check("stall_no_req", {31'b0, imem_req}, 32'd0);
            @(negedge clk);
        end

        // Release ready; redirect to 0x100 in the issue cycle of address 8
        hook_req_addr = 32'h8; hook_req_tgt = 32'h100; hook_req_en = 1;
        chk_gap = 1; ready_mode = 1;
        for (int i = 0; i < 60 && hook_req_en; i++) @(negedge clk);
        check("hook_issue_fired", {31'b0, hook_req_en}, 32'd0);

        // Redirect coincident with a live response; low bits must be dropped
        hook_rv_tgt = 32'h203; hook_rv_en = 1;
        for (int i = 0; i < 60 && hook_rv_en; i++) @(negedge clk);
        check("hook_rvalid_fired", {31'b0, hook_rv_en}, 32'd0);
        repeat (12) @(negedge clk);

        // Wrap from the top of the address space
        hook_now_tgt = 32'hFFFF_FFF8; hook_now_en = 1;
        repeat (30) @(negedge clk);
        chk_gap = 0;

        // Random traffic
        lat_mode = 0; ready_mode = 2; redir_rand = 1;
        repeat (3000) @(negedge clk);

        // Reset while a request is in flight
        redir_rand = 0; lat_mode = 3; ready_mode = 1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 40 && !imem_req; i++) @(negedge clk);
        check("pre_reset_req_seen", {31'b0, imem_req}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("midfetch_reset");
        release_reset();
        lat_mode = 1;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
